fifo_wr_arbiter: RTL

Shares one sync FIFO write port among NUM_REQ producers.
Round-robin arbitration with bounded bursts: a winner keeps the port for up to MAX_BURST consecutive writes, then releases it.
Drives the FIFO's w_en/data_in and observes its full flag. The FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_REQ_DEF   = 32'd4;
  localparam int unsigned DATA_W_DEF    = 32'd8;
  localparam int unsigned MAX_BURST_DEF = 32'd4;

  // Burst counter is one bit wider than needed so MAX_BURST itself is representable.
  function automatic int unsigned bcnt_width(input int unsigned max_burst);
    return $clog2(max_burst) + 32'd1;
  endfunction

  localparam int unsigned ID_W   = $clog2(NUM_REQ_DEF);
  localparam int unsigned BCNT_W = bcnt_width(MAX_BURST_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: first set bit of vec_i at or after start_i, wrapping.
module rr_picker #(
  parameter int unsigned N    = 32'd4,
  parameter int unsigned ID_W = 32'd2
) (
  input  logic [N-1:0]    vec_i,
  input  logic [ID_W-1:0] start_i,
  output logic [ID_W-1:0] idx_o,
  output logic            found_o
);

  logic [ID_W-1:0] cand_s;

  // Scan N candidates from start_i; index arithmetic wraps because N is a power of two
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand_s = start_i + ID_W'(i);
      if (!found_o && vec_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with each grant bounded to MAX_BURST writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_w_en,
  output logic [DATA_W-1:0]          fifo_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned GID_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = bcnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 32'd1);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [GID_W-1:0] winner_s;
  logic             found_s;
  logic             granted_s;
  logic             transfer_s;
  logic             release_s;
  logic [DATA_W-1:0] sel_data_s;

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (GID_W)
  ) u_picker (
    .vec_i   (req_valid),
    .start_i (rr_ptr_q),
    .idx_o   (winner_s),
    .found_o (found_s)
  );

  // Per-cycle beat decode for the granted requester
  always_comb begin
    granted_s  = (state_q == ARB_GRANT);
    transfer_s = granted_s & req_valid[grant_id_q] & ~fifo_full;
    release_s  = granted_s & (~req_valid[grant_id_q] |
                              (transfer_s & (burst_cnt_q == LAST_BEAT)));
    sel_data_s = req_data[grant_id_q*DATA_W +: DATA_W];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (found_s) state_d = ARB_GRANT;
        else         state_d = ARB_IDLE;
      end
      ARB_GRANT: begin
        if (release_s) state_d = ARB_IDLE;
        else           state_d = ARB_GRANT;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Pointer, grant and burst counter updates; a full stall simply holds everything
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        burst_cnt_d = '0;
        if (found_s) grant_id_d = winner_s;
        else         grant_id_d = grant_id_q;
      end
      ARB_GRANT: begin
        if (release_s) begin
          rr_ptr_d    = grant_id_q + GID_W'(1);
          burst_cnt_d = '0;
        end else if (transfer_s) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        rr_ptr_d    = '0;
        grant_id_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output muxing: ready tracks !full so a producer sees accept exactly when a write occurs
  always_comb begin
    req_ready = '0;
    fifo_w_en = 1'b0;
    fifo_data = '0;
    busy      = granted_s;
    if (granted_s) begin
      req_ready[grant_id_q] = ~fifo_full;
      fifo_w_en             = transfer_s;
      fifo_data             = transfer_s ? sel_data_s : '0;
    end else begin
      req_ready = '0;
    end
  end

  assign grant_id = grant_id_q;

endmodule
